// File: rtl/complex_pkg.sv
// Shared complex-sample types and the power-beat types used downstream of the FFT.
package complex_pkg;

  // One complex FFT bin: signed Q1.31 real and imaginary parts, real in the upper word.
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } complex;

  localparam int POWER_W    = 64;
  localparam int BEAT_IDX_W = 16;

  // Unsigned Q2.62 power value.
  typedef logic [POWER_W-1:0] power_t;

  // One power sample as handed to the mel filterbank.
  typedef struct packed {
    power_t                power;
    logic [BEAT_IDX_W-1:0] index;
    logic                  last;
  } power_beat_t;

  // Single-shot |X|^2; the largest sum, 2*2^62, still fits in 64 unsigned bits.
  function automatic power_t c_power(input complex c);
    logic signed [63:0] re_ext;
    logic signed [63:0] im_ext;
    power_t             re_sq;
    power_t             im_sq;
    re_ext = {{32{c.re[31]}}, c.re};
    im_ext = {{32{c.im[31]}}, c.im};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    return re_sq + im_sq;
  endfunction

endpackage

// File: rtl/power_calc.sv
// Squaring (S2) and summing (S3) stages of the power pipeline, frozen when en_i is low.
module power_calc
  import complex_pkg::*;
#(
  parameter int FFT_N = 512,
  parameter int IDX_W = $clog2(FFT_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  complex           data_i,
  input  logic [IDX_W-1:0] index_i,
  output logic             valid_o,
  output power_t           power_o,
  output logic [IDX_W-1:0] index_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] HalfIdx = IDX_W'(FFT_N / 2);

  logic signed [63:0] re_ext;
  logic signed [63:0] im_ext;
  logic               s2_valid_q;
  power_t             sq_re_q;
  power_t             sq_im_q;
  logic [IDX_W-1:0]   s2_index_q;

  // Sign-extend both parts so the 64-bit products are exact, including (-2^31)^2.
  always_comb begin
    re_ext = {{32{data_i.re[31]}}, data_i.re};
    im_ext = {{32{data_i.im[31]}}, data_i.im};
  end

  // S2: square each component.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sq_re_q    <= '0;
      sq_im_q    <= '0;
      s2_index_q <= '0;
    end else if (en_i) begin
      s2_valid_q <= valid_i;
      sq_re_q    <= re_ext * re_ext;
      sq_im_q    <= im_ext * im_ext;
      s2_index_q <= index_i;
    end
  end

  // S3: add the squares; output data only moves when a real sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      power_o <= '0;
      index_o <= '0;
      last_o  <= 1'b0;
    end else if (en_i) begin
      valid_o <= s2_valid_q;
      if (s2_valid_q) begin
        power_o <= sq_re_q + sq_im_q;
        index_o <= s2_index_q;
        last_o  <= (s2_index_q == HalfIdx);
      end
    end
  end

endmodule

// File: rtl/power_spectrum.sv
// Streaming power-spectrum stage: keeps bins 0..FFT_N/2, checks framing, counts frames.
module power_spectrum
  import complex_pkg::*;
#(
  parameter int FFT_N = 512,
  parameter int IDX_W = $clog2(FFT_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  complex           in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output power_t           out_power,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam logic [IDX_W-1:0] HalfIdx = IDX_W'(FFT_N / 2);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FFT_N - 1);

  logic             en;
  logic             accept;
  logic             s1_valid_q;
  logic             s1_keep_q;
  complex           s1_data_q;
  logic [IDX_W-1:0] s1_index_q;
  logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // The whole pipeline advances only when the output slot is free or being drained.
  always_comb begin
    en       = !out_valid || out_ready;
    in_ready = en;
    accept   = in_valid && en;
  end

  // Bin counter and framing checks: any frame end other than in_last on the final bin is an error.
  always_comb begin
    bin_cnt_d   = bin_cnt_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      if (in_last || (bin_cnt_q == LastIdx)) begin
        bin_cnt_d = '0;
        if (in_last && (bin_cnt_q == LastIdx)) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bin_cnt_d = bin_cnt_q + 1'b1;
      end
    end
  end

  // Framing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // S1: capture the bin with its index and whether it is a non-redundant bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_keep_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_index_q <= '0;
    end else if (en) begin
      s1_valid_q <= accept;
      s1_keep_q  <= (bin_cnt_q <= HalfIdx);
      s1_data_q  <= in_data;
      s1_index_q <= bin_cnt_q;
    end
  end

  power_calc #(
    .FFT_N (FFT_N),
    .IDX_W (IDX_W)
  ) u_power_calc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (s1_valid_q && s1_keep_q),
    .data_i  (s1_data_q),
    .index_i (s1_index_q),
    .valid_o (out_valid),
    .power_o (out_power),
    .index_o (out_index),
    .last_o  (out_last)
  );

  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/power_spectrum.md
# power_spectrum

Streaming power-spectrum stage placed directly downstream of the FFT. Consumes one complex FFT bin per accepted beat, computes the power |X|² = re² + im² in a 3-stage pipeline, and forwards only the non-redundant bins 0..FFT_N/2 to the mel filterbank. Bins above FFT_N/2 are accepted and dropped. Frame boundaries are checked against the expected length, and violations are flagged.

## Interface
Parameters:
- FFT_N, 512 — bins per frame; power of two, ≥ 8.
- IDX_W, $clog2(FFT_N) — width of bin index.

Ports:
- clk  in  1  — single clock; all logic rising-edge.
- rst_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — FFT bin present.
- in_ready  out  1  — stage can accept a bin.
- in_data  in  64  — complex bin, type complex (re, im signed Q1.31).
- in_last  in  1  — marks bin FFT_N-1 of a frame.
- out_valid  out  1  — power sample present.
- out_ready  in  1  — consumer accepts.
- out_power  out  64  — unsigned Q2.62 power.
- out_index  out  IDX_W  — bin number, 0..FFT_N/2.
- out_last  out  1  — high with bin FFT_N/2.
- frame_err  out  1  — sticky framing error; cleared only by reset.
- frame_cnt  out  16  — completed-frame count; wraps at 65535 → 0.

## Operation
- Handshake: a beat transfers when valid && ready on the same edge. Valid is never dropped while ready is low. Data is held stable while stalled.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. The whole pipeline freezes when en = 0.
- S1: register re, im, bin index and the keep flag (index ≤ FFT_N/2).
- S2: compute re*re and im*im as signed 32×32 → 64.
- S3: sum the two products as an unsigned 64-bit value. The maximum, 2·2⁶², fits without saturation. (-2³¹)² = 2⁶² is exact.
- Stages marked keep = 0 are bubbles. They never raise out_valid.
- Bin counter: increments on every accepted input beat and returns to 0 after a frame ends.
- Frame end occurs when the counter is at FFT_N-1, or when in_last is seen:
  - Normal end: in_last arrives with counter = FFT_N-1. The counter goes to 0 and frame_cnt increments.
  - Early in_last (counter < FFT_N-1): set frame_err, counter → 0, no frame_cnt increment. Bins already past S1 still drain with their original indices.
  - Missing in_last at counter = FFT_N-1: set frame_err, counter → 0 (wraps), no frame_cnt increment.
- out_last = (out_index == FFT_N/2).

## Timing
- Latency: 3 cycles from input acceptance to out_valid when unstalled. Throughput is 1 bin per cycle.
- Per frame: FFT_N input beats produce FFT_N/2+1 output beats. Stalls do not reorder or lose data.
- Reset values: in_ready = 1, out_valid = 0, out_power = 0, out_index = 0, out_last = 0, frame_err = 0, frame_cnt = 0. Bin counter and all pipeline valid bits = 0.
- Reset asserted mid-frame: all in-flight bins are discarded, and the next accepted beat is bin 0.
- Simultaneous output stall and input valid: in_ready = 0, and the input is not accepted that cycle.
- Output accepted and new input accepted in the same cycle: the pipeline advances by one.

## Structure
- complex_pkg (shared): reuse type complex and c_power. Add:
  - localparam POWER_W = 64.
  - typedef power_t (unsigned 64-bit).
  - typedef struct power_beat_t {power, index, last}.
- One sub-module, power_calc: S2 plus S3 (two multiplies and one add), with an enable input.
- Top level holds S1, the bin counter, framing checks, frame_cnt and the handshake.

## Test plan
- Ramp frame, FFT_N=8: bin k = (re = k·2²⁸, im = 0), in_last on k=7, out_ready=1 → 5 outputs. Output k has power k²·2⁵⁶ and index 0..4. out_last on index 4, frame_cnt = 1, frame_err = 0.
- Extremes: re = im = 0x8000_0000 → 0x8000_0000_0000_0000. re = 0x7FFF_FFFF, im = 0 → 0x3FFF_FFFF_0000_0001.
- Random backpressure (out_ready 40% duty) over 100 frames of random bins → outputs match the model in order. frame_cnt = 100. No beat lost or duplicated.
- in_last on bin 3 of an 8-bin frame → frame_err = 1, frame_cnt unchanged. The next beat is emitted as index 0.
- 9 beats with no in_last (FFT_N=8) → frame_err = 1 after beat 8. Beat 9 is emitted as index 0.
- rst_n pulsed low mid-frame with 3 bins in flight → out_valid = 0 immediately and no stale outputs. The following full frame produces exactly 5 outputs starting at index 0.
